mult_share_arbiter: RTL and testbench
=====================================

// Module: mult_share_arbiter
// PURPOSE
//  Shares one sequential N-bit signed multiplier (start/A/B -> Product/ready, N+1 cycle latency)
//  between NREQ requesters. Round-robin arbitration, operand capture, start pulse generation and
//  completion detection; returns the 2N-bit product tagged with the requester index.
//  Sits between client datapaths and the single multiplier instance.
// PARAMETERS
//  N        12  operand width (signed two's complement); product is 2N bits
//  NREQ     4   number of requesters (2..8)
//  IDW      2   requester index width, must equal $clog2(NREQ)
//  TMO      N+4 watchdog limit in cycles (used only with MULT_ARB_TIMEOUT_EN)
// PORTS
//  clk          in   1        system clock, all logic on rising edge
//  rst          in   1        asynchronous, active-high reset
//  req_valid    in   NREQ     per-requester request strobe, held until granted
//  req_a        in   NREQ*N   packed operand A, requester k at [k*N +: N]
//  req_b        in   NREQ*N   packed operand B, same packing
//  req_grant    out  NREQ     one-hot, 1-cycle pulse: operands of that requester captured
//  resp_valid   out  1        product available, held until resp_ready
//  resp_ready   in   1        consumer accepts response
//  resp_id      out  IDW      requester index of current response
//  resp_product out  2N       signed product A*B
//  busy         out  1        high in every state except IDLE
//  err_tmo      out  1        sticky watchdog flag (tied 0 without MULT_ARB_TIMEOUT_EN)
//  mul_start    out  1        to multiplier start, 1-cycle pulse
//  mul_a/mul_b  out  N        to multiplier A/B, stable while mul_start high
//  mul_product  in   2N       from multiplier Product
//  mul_ready    in   1        from multiplier ready
// BEHAVIOUR
//  Reset: state=IDLE, rr_ptr=0, all outputs 0 (req_grant, resp_*, mul_*, busy, err_tmo).
//  FSM IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
//   IDLE : if any req_valid, pick first set bit at or after rr_ptr (wrapping NREQ-1 -> 0);
//          pulse req_grant[k], latch req_a/req_b slice k and k into op regs, go ISSUE.
//          rr_ptr <= k+1 mod NREQ. No request: stay, no grant.
//   ISSUE: mul_start=1 for exactly this cycle, mul_a/mul_b driven from op regs; cnt<=0; go WAIT.
//   WAIT : cnt increments each cycle; mul_ready ignored while cnt==0 (stale ready from idle
//          multiplier); first mul_ready with cnt>=1 -> latch mul_product into resp_product, go RESP.
//          Nominal: resp_valid rises N+3 cycles after the grant cycle.
//   RESP : resp_valid=1, resp_id/resp_product stable; on resp_ready=1 drop resp_valid, go IDLE.
//  Throughput: at most one multiplication in flight; next grant no earlier than cycle after
//   response accepted. Same requester re-requesting does not starve others (pointer advanced).
//  req_valid deasserted before grant: request dropped silently, no error.
//  Simultaneous req_valid on all lines: grant order k, k+1, ... strictly rotating.
//  mul_a/mul_b hold last operands after ISSUE (multiplier ignores them without start).
//  Product is signed: resp_product equals $signed(A)*$signed(B) exactly, no truncation.
//  Reset mid-operation: FSM returns to IDLE immediately, any in-flight result discarded;
//   multiplier is reset by the same rst.
// CONFIGURATION
//  MULT_ARB_TIMEOUT_EN defined: in WAIT, if cnt reaches TMO without mul_ready, set err_tmo
//   (sticky until rst), return resp_valid with resp_product=0 and that resp_id, go RESP.
//  Not defined: no watchdog logic; WAIT waits indefinitely; err_tmo tied 0.
// STRUCTURE
//  Package mult_arb_pkg: state enum (IDLE, ISSUE, WAIT, RESP), localparam for state width,
//   helper function for wrapping round-robin pick.
//  One sub-module: rr_arbiter (NREQ-wide round-robin pick: req vector + ptr -> one-hot grant + idx).
//  The multiplier itself is instantiated outside this block, connected via mul_* ports.
// TESTING (bench wraps this block + 12-bit multiplier, NREQ=4)
//  1 Single req k=2, A=12'h005, B=12'hFFD (-3) -> grant[2] once, resp_id=2, product=24'hFFFFF1 (-15).
//  2 All 4 valid continuously, resp_ready=1 -> grants in order 0,1,2,3,0; each resp correct.
//  3 Extremes A=12'h800 (-2048), B=12'h800 -> product=24'h400000; A=-2048, B=2047 -> 24'hC00800.
//  4 resp_ready held 0 for 20 cycles -> resp_valid/id/product stable, no new grant, mul_start quiet.
//  5 rst asserted in WAIT -> next edge all outputs 0, IDLE; following request completes correctly.
//  6 (MULT_ARB_TIMEOUT_EN) mul_ready forced 0 -> err_tmo=1 after TMO cycles, resp_product=0.

Source files
------------

// File: rtl/mult_arb_pkg.sv
// Shared types and helpers for mult_share_arbiter and its round-robin picker.
package mult_arb_pkg;

  localparam int STATE_W = 2;
  localparam int MAX_REQ = 8;
  localparam int MAX_IDW = 3;

  typedef enum logic [STATE_W-1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_e;

  // Wrapping round-robin pick: first set bit of req at or after ptr, over nreq lines.
  // Returns {found, index}; index is meaningful only when found is set.
  function automatic logic [MAX_IDW:0] rr_pick(input logic [MAX_REQ-1:0] req,
                                               input logic [MAX_IDW-1:0] ptr,
                                               input int                 nreq);
    logic [MAX_IDW:0] res;
    int               idx;
    res = '0;
    for (int i = 0; i < MAX_REQ; i++) begin
      idx = (int'(ptr) + i) % nreq;
      if ((i < nreq) && !res[MAX_IDW] && req[idx[MAX_IDW-1:0]]) begin
        res = {1'b1, idx[MAX_IDW-1:0]};
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin picker: request vector plus priority pointer -> one-hot grant and index.
module rr_arbiter
  import mult_arb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IDW-1:0]  ptr_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [IDW-1:0]  idx_o,
  output logic            any_o
);

  logic [MAX_REQ-1:0] req_ext_s;
  logic [MAX_IDW-1:0] ptr_ext_s;
  logic [MAX_IDW:0]   pick_s;

  // Widen to the helper's fixed width, pick, and decode the winner to one-hot.
  always_comb begin
    req_ext_s            = '0;
    req_ext_s[NREQ-1:0]  = req_i;
    ptr_ext_s            = '0;
    ptr_ext_s[IDW-1:0]   = ptr_i;
    pick_s               = rr_pick(req_ext_s, ptr_ext_s, NREQ);
    idx_o                = pick_s[IDW-1:0];
    any_o                = pick_s[MAX_IDW];
    gnt_o                = '0;
    gnt_o[idx_o]         = any_o;
  end

endmodule

// File: rtl/mult_share_arbiter.sv
// mult_share_arbiter: shares one sequential signed multiplier between NREQ requesters.
// Optional watchdog on the multiplier handshake is compiled in with MULT_ARB_TIMEOUT_EN.
module mult_share_arbiter
  import mult_arb_pkg::*;
#(
  parameter int N    = 12,
  parameter int NREQ = 4,
  parameter int IDW  = 2,
  parameter int TMO  = N + 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*N-1:0] req_a,
  input  logic [NREQ*N-1:0] req_b,
  output logic [NREQ-1:0]   req_grant,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [IDW-1:0]    resp_id,
  output logic [2*N-1:0]    resp_product,
  output logic              busy,
  output logic              err_tmo,
  output logic              mul_start,
  output logic [N-1:0]      mul_a,
  output logic [N-1:0]      mul_b,
  input  logic [2*N-1:0]    mul_product,
  input  logic              mul_ready
);

  // Wide enough to reach TMO and saturate above it when the watchdog is absent.
  localparam int CNT_W = $clog2(TMO + 2) + 1;

  state_e           state_q, state_d;
  logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [NREQ-1:0]  grant_q, grant_d;
  logic             start_q, start_d;
  logic [N-1:0]     op_a_q, op_a_d;
  logic [N-1:0]     op_b_q, op_b_d;
  logic [IDW-1:0]   id_q, id_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rvalid_q, rvalid_d;
  logic [2*N-1:0]   product_q, product_d;
  logic             busy_q, busy_d;
`ifdef MULT_ARB_TIMEOUT_EN
  logic             err_tmo_q, err_tmo_d;
`endif

  logic [NREQ-1:0]  arb_gnt_s;
  logic [IDW-1:0]   arb_idx_s;
  logic             arb_any_s;
  logic [N-1:0]     sel_a_s, sel_b_s;

  rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_rr (
    .req_i (req_valid),
    .ptr_i (rr_ptr_q),
    .gnt_o (arb_gnt_s),
    .idx_o (arb_idx_s),
    .any_o (arb_any_s)
  );

  // Operand mux: the packed A/B slices belonging to the picked requester.
  always_comb begin
    sel_a_s = '0;
    sel_b_s = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (arb_idx_s == IDW'(k)) begin
        sel_a_s = req_a[k*N +: N];
        sel_b_s = req_b[k*N +: N];
      end else begin
        sel_a_s = sel_a_s;
        sel_b_s = sel_b_s;
      end
    end
  end

  // Next-state and next-output logic; every register holds unless a state says otherwise.
  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    grant_d   = '0;
    start_d   = 1'b0;
    op_a_d    = op_a_q;
    op_b_d    = op_b_q;
    id_d      = id_q;
    cnt_d     = cnt_q;
    rvalid_d  = rvalid_q;
    product_d = product_q;
`ifdef MULT_ARB_TIMEOUT_EN
    err_tmo_d = err_tmo_q;
`endif
    case (state_q)
      IDLE: begin
        if (arb_any_s) begin
          grant_d = arb_gnt_s;
          start_d = 1'b1;
          op_a_d  = sel_a_s;
          op_b_d  = sel_b_s;
          id_d    = arb_idx_s;
          if (arb_idx_s == IDW'(NREQ - 1)) begin
            rr_ptr_d = '0;
          end else begin
            rr_ptr_d = arb_idx_s + IDW'(1);
          end
          state_d = ISSUE;
        end else begin
          state_d = IDLE;
        end
      end
      ISSUE: begin
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        // Ready seen while cnt is still 0 is left over from the previous operation.
        if (mul_ready && (cnt_q != '0)) begin
          product_d = mul_product;
          rvalid_d  = 1'b1;
          state_d   = RESP;
`ifdef MULT_ARB_TIMEOUT_EN
        end else if (cnt_q == CNT_W'(TMO)) begin
          err_tmo_d = 1'b1;
          product_d = '0;
          rvalid_d  = 1'b1;
          state_d   = RESP;
`endif
        end else begin
          if (cnt_q != '1) begin
            cnt_d = cnt_q + CNT_W'(1);
          end else begin
            cnt_d = cnt_q;
          end
        end
      end
      RESP: begin
        if (resp_ready) begin
          rvalid_d = 1'b0;
          state_d  = IDLE;
        end else begin
          state_d  = RESP;
        end
      end
      default: begin
        rvalid_d = 1'b0;
        state_d  = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // State, pointer, operand and response registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      rr_ptr_q  <= '0;
      grant_q   <= '0;
      start_q   <= 1'b0;
      op_a_q    <= '0;
      op_b_q    <= '0;
      id_q      <= '0;
      cnt_q     <= '0;
      rvalid_q  <= 1'b0;
      product_q <= '0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      grant_q   <= grant_d;
      start_q   <= start_d;
      op_a_q    <= op_a_d;
      op_b_q    <= op_b_d;
      id_q      <= id_d;
      cnt_q     <= cnt_d;
      rvalid_q  <= rvalid_d;
      product_q <= product_d;
      busy_q    <= busy_d;
    end
  end

`ifdef MULT_ARB_TIMEOUT_EN
  // Sticky watchdog flag, cleared only by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_tmo_q <= 1'b0;
    end else begin
      err_tmo_q <= err_tmo_d;
    end
  end
  assign err_tmo = err_tmo_q;
`else
  assign err_tmo = 1'b0;
`endif

  assign req_grant    = grant_q;
  assign mul_start    = start_q;
  assign mul_a        = op_a_q;
  assign mul_b        = op_b_q;
  assign resp_valid   = rvalid_q;
  assign resp_id      = id_q;
  assign resp_product = product_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Bench for mult_share_arbiter with a behavioural 12-bit sequential multiplier, NREQ=4.
`timescale 1ns/1ps
module tb_mult_share_arbiter;

  localparam int N    = 12;
  localparam int NREQ = 4;
  localparam int IDW  = 2;
  localparam int TMO  = N + 4;

  logic              clk;
  logic              rst;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ*N-1:0] req_a;
  logic [NREQ*N-1:0] req_b;
  logic [NREQ-1:0]   req_grant;
  logic              resp_valid;
  logic              resp_ready;
  logic [IDW-1:0]    resp_id;
  logic [2*N-1:0]    resp_product;
  logic              busy;
  logic              err_tmo;
  logic              mul_start;
  logic [N-1:0]      mul_a;
  logic [N-1:0]      mul_b;
  logic [2*N-1:0]    mul_product;
  logic              mul_ready;
  logic              mul_kill;

  mult_share_arbiter #(.N(N), .NREQ(NREQ), .IDW(IDW), .TMO(TMO)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_a        (req_a),
    .req_b        (req_b),
    .req_grant    (req_grant),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .resp_id      (resp_id),
    .resp_product (resp_product),
    .busy         (busy),
    .err_tmo      (err_tmo),
    .mul_start    (mul_start),
    .mul_a        (mul_a),
    .mul_b        (mul_b),
    .mul_product  (mul_product),
    .mul_ready    (mul_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural sequential multiplier: ready stays high when idle, drops one cycle after
  // start, and rises with the product N+1 edges after start was sampled.
  logic           m_start_d;
  logic [4:0]     m_cnt;
  logic           m_ready;
  logic [2*N-1:0] m_prod;
  logic [N-1:0]   m_a, m_b;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_start_d <= 1'b0;
      m_cnt     <= 5'd0;
      m_ready   <= 1'b0;
      m_prod    <= '0;
      m_a       <= '0;
      m_b       <= '0;
    end else begin
      m_start_d <= mul_start;
      if (mul_start) begin
        m_a <= mul_a;
        m_b <= mul_b;
      end
      if (m_start_d) begin
        m_ready <= 1'b0;
        m_cnt   <= 5'(N);
      end else if (m_cnt != 5'd0) begin
        m_cnt <= m_cnt - 5'd1;
        if (m_cnt == 5'd1) begin
          m_ready <= 1'b1;
          m_prod  <= $signed(m_a) * $signed(m_b);
        end
      end
    end
  end

  assign mul_product = m_prod;
  assign mul_ready   = m_ready & ~mul_kill;

  // Watchdog against a hung run.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  int          n_checks = 0;
  int          n_fail   = 0;
  int          ptr_m    = 0;
  logic        err_m    = 1'b0;
  int          last_k;
  logic [23:0] last_prod;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %h required %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [23:0] smul(input logic [11:0] a, input logic [11:0] b);
    logic signed [23:0] r;
    r = $signed(a) * $signed(b);
    return r;
  endfunction

  function automatic int model_pick(input logic [3:0] req, input int ptr);
    for (int i = 0; i < NREQ; i++) begin
      if (req[(ptr + i) % NREQ]) return (ptr + i) % NREQ;
    end
    return 0;
  endfunction

  function automatic logic [63:0] outs();
    return 64'({req_grant, resp_valid, resp_id, resp_product, busy, err_tmo,
                mul_start, mul_a, mul_b});
  endfunction

  // One full transaction for the requester the round-robin rule should pick now.
  task automatic serve(input string nm, input bit drop, input int hold, input bit tmo);
    int          k, t, lat, exp_lat;
    logic [3:0]  exp_g;
    logic [11:0] a, b;
    logic [23:0] exp_p;
    k       = model_pick(req_valid, ptr_m);
    exp_g   = 4'b0001 << k;
    a       = req_a[k*N +: N];
    b       = req_b[k*N +: N];
    exp_p   = tmo ? 24'h0 : smul(a, b);
    exp_lat = tmo ? (TMO + 2) : (N + 3);
    t = 0;
    while (req_grant == 4'b0 && t < 20) begin
      step();
      t++;
    end
    check({nm, "_grant"}, 64'({req_grant, busy, mul_start, mul_a, mul_b}),
          64'({exp_g, 1'b1, 1'b1, a, b}));
    ptr_m  = (k + 1) % NREQ;
    last_k = k;
    if (drop) req_valid[k] = 1'b0;
    step();
    lat = 1;
    check({nm, "_pulse"}, 64'({req_grant, mul_start}), 64'h0);
    while (resp_valid !== 1'b1 && lat < 60) begin
      step();
      lat++;
    end
    if (tmo) err_m = 1'b1;
    last_prod = resp_product;
    check({nm, "_lat"}, 64'(lat), 64'(exp_lat));
    check({nm, "_resp"}, 64'({resp_id, resp_product, err_tmo, busy}),
          64'({2'(k), exp_p, err_m, 1'b1}));
    for (int h = 0; h < hold; h++) begin
      step();
      check({nm, "_hold"}, 64'({resp_valid, resp_id, resp_product, req_grant, mul_start}),
            64'({1'b1, 2'(k), exp_p, 4'b0, 1'b0}));
    end
    resp_ready = 1'b1;
    step();
    resp_ready = 1'b0;
    check({nm, "_done"}, 64'({resp_valid, busy, req_grant}), 64'h0);
  endtask

  typedef struct {
    int          k;
    logic [11:0] a;
    logic [11:0] b;
    logic [23:0] p;
  } vec_t;

  vec_t tbl [7];
  int   order [5];

  initial begin
    int t, d;
    logic [3:0] mask;

    tbl[0] = '{2, 12'h005, 12'hFFD, 24'hFFFFF1};
    tbl[1] = '{0, 12'h800, 12'h800, 24'h400000};
    tbl[2] = '{1, 12'h800, 12'h7FF, 24'hC00800};
    tbl[3] = '{3, 12'h7FF, 12'h7FF, 24'h3FF001};
    tbl[4] = '{0, 12'h000, 12'hABC, 24'h000000};
    tbl[5] = '{3, 12'hFFF, 12'hFFF, 24'h000001};
    tbl[6] = '{1, 12'h001, 12'h800, 24'hFFF800};
    order  = '{0, 1, 2, 3, 0};

    rst        = 1'b1;
    req_valid  = '0;
    req_a      = '0;
    req_b      = '0;
    resp_ready = 1'b0;
    mul_kill   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outs", outs(), 64'h0);
    rst = 1'b0;
    step();
    check("idle_outs", outs(), 64'h0);

    // All four requesters valid continuously: strict rotation from pointer 0.
    for (int r = 0; r < NREQ; r++) begin
      req_a[r*N +: N] = 12'(r * 37 + 5);
      req_b[r*N +: N] = 12'hF00 + 12'(r);
    end
    req_valid = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      serve($sformatf("rr%0d", i), 1'b0, 0, 1'b0);
      check($sformatf("rr%0d_order", i), 64'(last_k), 64'(order[i]));
    end
    req_valid = 4'b0000;

    // Directed vectors: single requester, product checked against fixed constants.
    for (int i = 0; i < 7; i++) begin
      req_a[tbl[i].k*N +: N] = tbl[i].a;
      req_b[tbl[i].k*N +: N] = tbl[i].b;
      req_valid[tbl[i].k]    = 1'b1;
      serve($sformatf("vec%0d", i), 1'b1, 0, 1'b0);
      check($sformatf("vec%0d_id", i), 64'({2'(last_k), last_prod}),
            64'({2'(tbl[i].k), tbl[i].p}));
    end

    // Consumer stall for 20 cycles with another request waiting.
    req_a[0*N +: N] = 12'h100;
    req_b[0*N +: N] = 12'h002;
    req_a[2*N +: N] = 12'h7F0;
    req_b[2*N +: N] = 12'h811;
    req_valid = 4'b0101;
    serve("stall", 1'b1, 20, 1'b0);
    serve("after_stall", 1'b1, 0, 1'b0);

    // Randomized traffic with occasional withdrawn requests.
    for (int it = 0; it < 12; it++) begin
      mask = 4'($urandom_range(1, 15));
      for (int r = 0; r < NREQ; r++) begin
        if (mask[r]) begin
          req_a[r*N +: N] = 12'($urandom);
          req_b[r*N +: N] = 12'($urandom);
        end
      end
      req_valid = mask;
      while (req_valid != 4'b0) begin
        d = $urandom_range(0, 3);
        if (req_valid[d] && ($countones(req_valid) > 1) && ($urandom_range(0, 7) == 0)) begin
          req_valid[d] = 1'b0;
        end
        serve($sformatf("rnd%0d", it), 1'b1, $urandom_range(0, 3), 1'b0);
      end
    end

    // Reset while waiting on the multiplier.
    req_a[1*N +: N] = 12'h123;
    req_b[1*N +: N] = 12'h045;
    req_valid = 4'b0010;
    t = 0;
    while (req_grant == 4'b0 && t < 20) begin
      step();
      t++;
    end
    check("rstw_grant", 64'(req_grant), 64'h2);
    req_valid = 4'b0000;
    repeat (4) step();
    check("rstw_busy", 64'({busy, resp_valid}), 64'h2);
    rst = 1'b1;
    #1;
    check("rstw_outs", outs(), 64'h0);
    step();
    check("rstw_outs_edge", outs(), 64'h0);
    rst   = 1'b0;
    ptr_m = 0;
    err_m = 1'b0;
    step();
    req_a[3*N +: N] = 12'h0C8;
    req_b[3*N +: N] = 12'hF9C;
    req_a[0*N +: N] = 12'h3E7;
    req_b[0*N +: N] = 12'h00A;
    req_valid = 4'b1001;
    serve("post_rst0", 1'b1, 1, 1'b0);
    serve("post_rst1", 1'b1, 0, 1'b0);

`ifdef MULT_ARB_TIMEOUT_EN
    // Multiplier never answers: watchdog returns a zero product and flags the error.
    mul_kill = 1'b1;
    req_a[2*N +: N] = 12'h00A;
    req_b[2*N +: N] = 12'h00B;
    req_valid = 4'b0100;
    serve("tmo", 1'b1, 2, 1'b1);
    mul_kill = 1'b0;
    repeat (20) step();
    req_a[1*N +: N] = 12'h011;
    req_b[1*N +: N] = 12'hFF0;
    req_valid = 4'b0010;
    serve("tmo_after", 1'b1, 0, 1'b0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
